// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-side memory responder: the MMIO register
// map, the STATUS bit layout and the timer state encoding.
package dmem_responder_pkg;

    // Word offsets inside the MMIO region (address bits [7:0]).
    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TIMER  = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_GPIO   = 8'h0C;

    // STATUS register bit positions.
    localparam int STAT_EXPIRED = 0;
    localparam int STAT_RUNNING = 1;
    localparam int STAT_ERR     = 2;

    // One-shot down-timer states.
    typedef enum logic [0:0] {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } timer_state_e;

    // Assemble the STATUS read value; unused bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic expired,
        input logic running,
        input logic err
    );
        logic [31:0] word;
        word               = '0;
        word[STAT_EXPIRED] = expired;
        word[STAT_RUNNING] = running;
        word[STAT_ERR]     = err;
        return word;
    endfunction

endpackage

// File: rtl/dmem_responder_timer.sv
// One-shot down-timer for the MMIO region: a 32-bit count, an IDLE/RUN
// state machine and the sticky EXPIRED flag. A load of N starts an N-cycle
// count; a load of zero expires immediately without ever running.
module mmio_timer
    import dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        clear,
    output logic [31:0] count,
    output logic        running,
    output logic        expired
);

    timer_state_e state;
    logic         expire_now;

    // Expiry happens on a load of zero or on the 1 -> 0 step of a running count;
    // a non-zero load suppresses the decrement, so it also suppresses expiry.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        expire_now = 1'b0;
        if (load) begin
            expire_now = (load_value == 32'd0);
        end else if (state == TMR_RUN && count == 32'd1) begin
            expire_now = 1'b1;
        end
    end

    // Count and state update: a load (reload) always wins over the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use nonblocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= TMR_IDLE;
            count <= 32'd0;
        end else if (load) begin
            count <= load_value;
            state <= (load_value == 32'd0) ? TMR_IDLE : TMR_RUN;
        end else if (state == TMR_RUN) begin
            count <= count - 32'd1;
            if (count == 32'd1) begin
                state <= TMR_IDLE;
            end
        end
    end

    // Sticky EXPIRED flag: a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (expire_now) begin
            expired <= 1'b1;
        end else if (clear) begin
            expired <= 1'b0;
        end
    end

    assign running = (state == TMR_RUN);

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder for the pipelined MIPS core's M stage.
// Serves loads combinationally and commits stores on the rising edge.
// Address map: bits [31:16] == MMIO_TAG select the MMIO registers
// (CYCLE, TIMER, STATUS, GPIO); everything else hits a word-addressed RAM
// whose upper addresses alias. RAM_WORDS must be a power of two, >= 2.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter logic [15:0] MMIO_TAG  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        memwriteM,
    output logic [31:0] readdataM,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    // Address decode.
    logic             is_mmio;
    logic             aligned;
    logic [7:0]       offset;
    logic [IDX_W-1:0] ram_idx;

    // Write strobes.
    logic             misaligned_store;
    logic             ram_we;
    logic             mmio_we;
    logic             timer_load;
    logic             status_we;
    logic             gpio_we;
    logic             clear_expired;
    logic             clear_err;

    // Architectural state.
    logic [31:0]      ram [RAM_WORDS];
    logic [31:0]      cycle_q;
    logic             err_q;
    logic [31:0]      gpio_q;

    // Timer outputs.
    logic [31:0]      timer_count;
    logic             timer_running;
    logic             timer_expired;

    // Address bits [15:8] take no part in decode: MMIO offsets alias over
    // them, and RAM indexing only reaches them for very deep RAMs.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^aluoutM[15:8];

    // Region select, word offset (byte lane bits ignored) and RAM index.
    assign is_mmio = (aluoutM[31:16] == MMIO_TAG);
    assign aligned = (aluoutM[1:0] == 2'b00);
    assign offset  = {aluoutM[7:2], 2'b00};
    assign ram_idx = aluoutM[IDX_W+1:2];

    // A misaligned store is dropped everywhere and only raises ERR.
    assign misaligned_store = memwriteM && !aligned;
    assign ram_we           = memwriteM && aligned && !is_mmio;
    assign mmio_we          = memwriteM && aligned &&  is_mmio;

    assign timer_load    = mmio_we && (offset == OFF_TIMER);
    assign status_we     = mmio_we && (offset == OFF_STATUS);
    assign gpio_we       = mmio_we && (offset == OFF_GPIO);
    assign clear_expired = status_we && writedataM[STAT_EXPIRED];
    assign clear_err     = status_we && writedataM[STAT_ERR];

    // Data RAM: full-word stores, no reset.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array deliberately has no reset; resetting it would
        // prevent mapping onto memory macros and contents are undefined
        // until software writes them.
        if (ram_we) begin
            ram[ram_idx] <= writedataM;
        end
    end

    // Free-running cycle counter; writes to its offset are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Sticky ERR flag: a misaligned store on the same edge as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (misaligned_store) begin
            err_q <= 1'b1;
        end else if (clear_err) begin
            err_q <= 1'b0;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= 32'd0;
        end else if (gpio_we) begin
            gpio_q <= writedataM;
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load       (timer_load),
        .load_value (writedataM),
        .clear      (clear_expired),
        .count      (timer_count),
        .running    (timer_running),
        .expired    (timer_expired)
    );

    // Zero-latency read mux over RAM and the MMIO registers.
    always_comb begin
        readdataM = 32'd0;
        if (is_mmio) begin
            case (offset)
                OFF_CYCLE:  readdataM = cycle_q;
                OFF_TIMER:  readdataM = timer_count;
                OFF_STATUS: readdataM = pack_status(timer_expired, timer_running, err_q);
                OFF_GPIO:   readdataM = gpio_q;
                default:    readdataM = 32'd0;
            endcase
        end else begin
            readdataM = ram[ram_idx];
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = timer_expired;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A reference model tracks the
// memory image, the free-running cycle value, the timer as an absolute
// expiry edge number, and the sticky flags; randomized traffic is compared
// against it alongside directed scenarios.
module tb_dmem_responder;

    localparam int          RAM_WORDS = 64;
    localparam logic [31:0] A_CYCLE   = 32'hFFFF_0000;
    localparam logic [31:0] A_TIMER   = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
    localparam logic [31:0] A_GPIO    = 32'hFFFF_000C;
    localparam logic [31:0] A_UNMAP   = 32'hFFFF_0010;

    logic        clk;
    logic        reset;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        memwriteM;
    logic [31:0] readdataM;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int checks;
    int errors;

    // Reference model state.
    logic [31:0] m_ram [RAM_WORDS];
    logic [31:0] m_cycle;
    int unsigned m_edge;
    int unsigned m_deadline;
    bit          m_armed;
    bit          m_exp;
    bit          m_err;
    logic [31:0] m_gpio;

    dmem_responder #(.RAM_WORDS(RAM_WORDS), .MMIO_TAG(16'hFFFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .memwriteM  (memwriteM),
        .readdataM  (readdataM),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_mmio_addr(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    function automatic int ram_index(input logic [31:0] a);
        return int'((a >> 2) % RAM_WORDS);
    endfunction

    // Expected load value given the model state before the next edge.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (is_mmio_addr(a)) begin
            case (a[7:0] & 8'hFC)
                8'h00: r = m_cycle;
                8'h04: r = m_armed ? 32'(m_deadline - m_edge) : 32'd0;
                8'h08: r = {29'd0, m_err, m_armed, m_exp};
                8'h0C: r = m_gpio;
                default: r = 32'd0;
            endcase
        end else begin
            r = m_ram[ram_index(a)];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cycle    = 32'd0;
        m_edge     = 0;
        m_deadline = 0;
        m_armed    = 1'b0;
        m_exp      = 1'b0;
        m_err      = 1'b0;
        m_gpio     = 32'd0;
    endtask

    // Advance the model by one rising edge carrying the given request.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input bit we);
        bit set_e;
        bit clr_e;
        bit tw;
        set_e = 1'b0;
        clr_e = 1'b0;
        tw    = 1'b0;
        m_edge  = m_edge + 1;
        m_cycle = m_cycle + 32'd1;
        if (we) begin
            if (a[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else if (is_mmio_addr(a)) begin
                case (a[7:0])
                    8'h04: begin
                        tw         = 1'b1;
                        m_deadline = m_edge + d;
                        m_armed    = (d != 0);
                        if (d == 0) set_e = 1'b1;
                    end
                    8'h08: begin
                        clr_e = d[0];
                        if (d[2]) m_err = 1'b0;
                    end
                    8'h0C: m_gpio = d;
                    default: ;
                endcase
            end else begin
                m_ram[ram_index(a)] = d;
            end
        end
        if (!tw && m_armed && m_edge == m_deadline) begin
            m_armed = 1'b0;
            set_e   = 1'b1;
        end
        if (set_e)      m_exp = 1'b1;
        else if (clr_e) m_exp = 1'b0;
    endtask

    // One bus cycle: drive at the falling edge, sample the load just before
    // the rising edge, step the model, return at the next falling edge.
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input bit we,
                            output logic [31:0] rd);
        aluoutM    = a;
        writedataM = d;
        memwriteM  = we;
        #1 rd = readdataM;
        @(posedge clk);
        model_step(a, d, we);
        @(negedge clk);
        memwriteM = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] rd);
        aluoutM   = a;
        memwriteM = 1'b0;
        #1 rd = readdataM;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset      = 1'b0;
        memwriteM  = 1'b0;
        aluoutM    = 32'd0;
        writedataM = 32'd0;
        repeat (2) @(negedge clk);
        model_reset();
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'd0); end
        checks++;
        if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        reset = 1'b1;
        peek(A_CYCLE, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %h expected %h", rd, 32'd0); end
        peek(A_TIMER, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_timer: got %h expected %h", rd, 32'd0); end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] a;
        // Give every RAM word a known value before anything reads it.
        for (int i = 0; i < RAM_WORDS; i++) begin
            do_cycle(32'(i * 4), $urandom, 1'b1, rd);
        end
        exp = model_read(32'h40);
        do_cycle(32'h40, 32'hDEAD_BEEF, 1'b1, rd);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL ram_same_cycle_old: got %h expected %h", rd, exp); end
        peek(32'h40, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_next_cycle: got %h expected %h", rd, 32'hDEAD_BEEF); end
        do_cycle(32'h40 + 4 * RAM_WORDS, 32'hCAFE_F00D, 1'b1, rd);
        peek(32'h40, rd);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_alias: got %h expected %h", rd, 32'hCAFE_F00D); end
        for (int i = 0; i < 40; i++) begin
            a   = {16'($urandom_range(0, 16'hFFFE)), 14'($urandom), 2'b00};
            exp = model_read(a);
            do_cycle(a, $urandom, 1'($urandom), rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL ram_random[%0d] @%h: got %h expected %h", i, a, rd, exp); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic [31:0] exp;
        exp = model_read(32'h40);
        do_cycle(32'h41, 32'h0000_1234, 1'b1, rd);
        peek(32'h40, rd);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL misaligned_ram_kept: got %h expected %h", rd, exp); end
        peek(32'h42, rd);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL misaligned_load: got %h expected %h", rd, exp); end
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL misaligned_err_set: got %h expected %h", rd, 32'h4); end
        do_cycle(A_STATUS, 32'h4, 1'b1, rd);
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL err_w1c: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        logic [31:0] exp;
        do_cycle(A_TIMER, 32'd5, 1'b1, rd);
        for (int i = 0; i < 7; i++) begin
            exp = model_read(A_STATUS);
            do_cycle(A_STATUS, 32'd0, 1'b0, rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL timer_status[%0d]: got %h expected %h", i, rd, exp); end
            checks++;
            if (timer_irq !== m_exp) begin errors++; $display("FAIL timer_irq[%0d]: got %b expected %b", i, timer_irq, m_exp); end
        end
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
        do_cycle(A_TIMER, 32'd5, 1'b1, rd);
        for (int i = 0; i < 6; i++) begin
            exp = model_read(A_TIMER);
            do_cycle(A_TIMER, 32'd0, 1'b0, rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL timer_count[%0d]: got %h expected %h", i, rd, exp); end
        end
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
        do_cycle(A_TIMER, 32'd5, 1'b1, rd);
        repeat (3) do_cycle(A_TIMER, 32'd0, 1'b0, rd);
        peek(A_TIMER, rd);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL timer_before_reload: got %h expected %h", rd, 32'd2); end
        do_cycle(A_TIMER, 32'd10, 1'b1, rd);
        for (int i = 0; i < 12; i++) begin
            exp = model_read(A_STATUS);
            do_cycle(A_STATUS, 32'd0, 1'b0, rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL reload_status[%0d]: got %h expected %h", i, rd, exp); end
            checks++;
            if (timer_irq !== m_exp) begin errors++; $display("FAIL reload_irq[%0d]: got %b expected %b", i, timer_irq, m_exp); end
        end
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
    endtask

    task automatic test_timer_bounds();
        logic [31:0] rd;
        do_cycle(A_TIMER, 32'd0, 1'b1, rd);
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL timer_zero_load: got %h expected %h", rd, 32'h1); end
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL expired_w1c: got %h expected %h", rd, 32'h0); end
        do_cycle(A_TIMER, 32'd3, 1'b1, rd);
        repeat (2) do_cycle(A_STATUS, 32'd0, 1'b0, rd);
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL expiry_beats_w1c: got %h expected %h", rd, 32'h1); end
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL expiry_beats_w1c_irq: got %b expected 1", timer_irq); end
        do_cycle(A_STATUS, 32'h1, 1'b1, rd);
    endtask

    task automatic test_cycle_gpio();
        logic [31:0] rd;
        logic [31:0] exp;
        exp = model_read(A_CYCLE);
        do_cycle(A_CYCLE, $urandom, 1'b1, rd);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL cycle_k: got %h expected %h", rd, exp); end
        peek(A_CYCLE, rd);
        checks++;
        if (rd !== exp + 32'd1) begin errors++; $display("FAIL cycle_k_plus_1: got %h expected %h", rd, exp + 32'd1); end
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFF;
        do_cycle(A_CYCLE, 32'd0, 1'b0, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max: got %h expected %h", rd, 32'hFFFF_FFFF); end
        peek(A_CYCLE, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL cycle_wrap: got %h expected %h", rd, 32'd0); end
        do_cycle(A_GPIO, 32'hA5A5_0F0F, 1'b1, rd);
        checks++;
        if (gpio_out !== 32'hA5A5_0F0F) begin errors++; $display("FAIL gpio_out: got %h expected %h", gpio_out, 32'hA5A5_0F0F); end
        peek(A_GPIO, rd);
        checks++;
        if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL gpio_read: got %h expected %h", rd, 32'hA5A5_0F0F); end
        do_cycle(A_UNMAP, 32'h1111_2222, 1'b1, rd);
        peek(A_UNMAP, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", rd, 32'd0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_cycle(A_GPIO, 32'h0000_1357, 1'b1, rd);
        do_cycle(A_TIMER, 32'd20, 1'b1, rd);
        repeat (3) do_cycle(A_TIMER, 32'd0, 1'b0, rd);
        reset = 1'b0;
        model_reset();
        peek(A_STATUS, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_status: got %h expected %h", rd, 32'd0); end
        peek(A_TIMER, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_timer: got %h expected %h", rd, 32'd0); end
        checks++;
        if (gpio_out !== 32'd0) begin errors++; $display("FAIL midreset_gpio: got %h expected %h", gpio_out, 32'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", timer_irq); end
        reset = 1'b1;
        do_cycle(A_CYCLE, 32'd0, 1'b0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL restart_cycle0: got %h expected %h", rd, 32'd0); end
        peek(A_CYCLE, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL restart_cycle1: got %h expected %h", rd, 32'd1); end
    endtask

    task automatic test_random_mix();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 6))
                0, 1:    a = {16'($urandom_range(0, 16'hFFFE)), 14'($urandom), 2'b00};
                2:       a = 32'hFFFF_0000 | 32'($urandom_range(0, 5) * 4);
                3:       a = A_TIMER;
                4:       a = A_STATUS;
                5:       a = {16'hFFFF, 8'($urandom), 8'($urandom)};
                default: a = {16'($urandom), 14'($urandom), 2'($urandom)};
            endcase
            d = (a[7:0] == 8'h04) ? 32'($urandom_range(0, 12)) : $urandom;
            exp = model_read(a);
            do_cycle(a, d, we, rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL random_read[%0d] @%h: got %h expected %h", i, a, rd, exp); end
            checks++;
            if (timer_irq !== m_exp || gpio_out !== m_gpio) begin
                errors++;
                $display("FAIL random_outputs[%0d]: got irq=%b gpio=%h expected irq=%b gpio=%h",
                         i, timer_irq, gpio_out, m_exp, m_gpio);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_ram();
        test_misaligned();
        test_timer();
        test_timer_bounds();
        test_cycle_gpio();
        test_reset_mid();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
